// File: rtl/sp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_fifo_ctrl
// Purpose  : Byte FIFO controller that keeps 32 entries in an external
//            single-port RAM and adds a one-byte output register in front of
//            the consumer, giving a total capacity of 33 bytes.
//
// Ports    : clk              - sole clock, rising edge
//            rst_n            - synchronous active-low reset
//            in_valid/in_data - producer byte, accepted on in_valid & in_ready
//            in_ready         - FIFO can take the producer byte this cycle
//            out_valid        - out_data holds a byte
//            out_data         - consumer byte
//            out_ready        - consumer takes the byte on out_valid & out_ready
//            mem_data         - RAM write data
//            mem_address      - RAM address (bit 5 always 0)
//            mem_en           - RAM enable
//            mem_write_enable - RAM write (1) / read (0)
//            mem_q            - RAM read data, one cycle after the read issue
//            count            - bytes held in RAM, 0..32
//            full             - count == 32
//            empty            - nothing in RAM and nothing in the output register
//
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_fifo_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [7:0] mem_data,
    output logic [5:0] mem_address,
    output logic       mem_en,
    output logic       mem_write_enable,
    input  logic [7:0] mem_q,
    output logic [5:0] count,
    output logic       full,
    output logic       empty
);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_RD_WAIT = 1'b1;
    localparam logic [5:0] c_FULL_COUNT = 6'd32;

    logic [0:0] r_state;
    logic [4:0] r_wr_ptr;
    logic [4:0] r_rd_ptr;
    logic [5:0] r_count;
    logic       r_out_valid;
    logic [7:0] r_out_data;

    logic       w_full;
    logic       w_prefetch;
    logic       w_rd_access;
    logic       w_in_ready;
    logic       w_push;
    logic       w_pop;

    // Refill of the output register has priority over writes: it is only
    // started from the registered out_valid, so a pop and a prefetch can
    // never share a cycle. Everything is gated by rst_n so that the RAM
    // bus stays quiet and in_ready stays low while reset is held.
    always_comb begin
        w_full      = (r_count == c_FULL_COUNT);
        w_prefetch  = rst_n && (r_state == c_ST_IDLE) && !r_out_valid && (r_count != 6'd0);
        w_rd_access = w_prefetch || (rst_n && (r_state == c_ST_RD_WAIT));
        w_in_ready  = rst_n && (r_state == c_ST_IDLE) && !w_prefetch && !w_full;
        w_push      = in_valid && w_in_ready;
        w_pop       = r_out_valid && out_ready;
    end

    // RAM bus: read pair (issue + wait) holds the same address so mem_q is
    // valid during RD_WAIT; otherwise a single write cycle or an idle bus.
    always_comb begin
        mem_en           = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 6'd0;
        mem_data         = 8'd0;
        if (w_rd_access) begin
            mem_en      = 1'b1;
            mem_address = {1'b0, r_rd_ptr};
        end else if (w_push) begin
            mem_en           = 1'b1;
            mem_write_enable = 1'b1;
            mem_address      = {1'b0, r_wr_ptr};
            mem_data         = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_wr_ptr    <= 5'd0;
            r_rd_ptr    <= 5'd0;
            r_count     <= 6'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_prefetch) begin
                        r_state <= c_ST_RD_WAIT;
                    end else if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 5'd1;
                        r_count  <= r_count + 6'd1;
                    end
                end
                c_ST_RD_WAIT: begin
                    // out_valid is known low here, so this cannot collide
                    // with the pop clear above.
                    r_out_data  <= mem_q;
                    r_out_valid <= 1'b1;
                    r_rd_ptr    <= r_rd_ptr + 5'd1;
                    r_count     <= r_count - 6'd1;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = (r_count == 6'd0) && !r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_fifo_ctrl
// Purpose  : Directed self-checking bench for sp_ram_fifo_ctrl with a
//            behavioural single-port RAM, a byte-order scoreboard and a
//            per-cycle RAM bus protocol monitor.
//
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [7:0] mem_data;
    logic [5:0] mem_address;
    logic       mem_en;
    logic       mem_write_enable;
    logic [7:0] mem_q = 8'd0;
    logic [5:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sp_ram_fifo_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .mem_data         (mem_data),
        .mem_address      (mem_address),
        .mem_en           (mem_en),
        .mem_write_enable (mem_write_enable),
        .mem_q            (mem_q),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    // Synchronous single-port RAM: read data registered one cycle after issue.
    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write_enable) ram[mem_address] <= mem_data;
            else                  mem_q <= ram[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record handshakes of the current cycle, then move to the next negedge.
    task automatic advance();
        if (in_valid && in_ready) q.push_back(in_data);
        if (out_valid && out_ready) begin
            rx_cnt++;
            if (q.size() == 0) chk("sb_spurious_pop", q.size(), 1);
            else               chk("sb_order", out_data, q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < bound && q.size() != 0; i++) begin
            #1;
            advance();
        end
        #1;
        chk("drain_left", q.size(), 0);
        chk("drain_empty", empty, 1'b1);
        chk("drain_count", count, 6'd0);
        advance();
    endtask

    // RAM bus monitor: reads come as issue+wait pairs on one address, no
    // write inside a pair, idle bus is all zero, flags consistent with count.
    logic       pend = 1'b0;
    logic [5:0] pend_addr = 6'd0;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            pend = 1'b0;
            chk("rst_mem_en", mem_en, 1'b0);
        end else begin
            if (mem_en) begin
                if (pend) begin
                    chk("pair_we", mem_write_enable, 1'b0);
                    chk("pair_addr", mem_address, pend_addr);
                    pend = 1'b0;
                end else if (!mem_write_enable) begin
                    pend      = 1'b1;
                    pend_addr = mem_address;
                end
            end else begin
                chk("pair_broken", pend, 1'b0);
                pend = 1'b0;
                chk("idle_bus", {mem_write_enable, mem_address, mem_data}, 0);
            end
            chk("addr_b5", mem_address[5], 1'b0);
            chk("count_max", (count <= 6'd32), 1'b1);
            chk("full_cons", full, (count == 6'd32));
            chk("empty_cons", empty, (count == 6'd0) && !out_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int nxt;
    int sent;
    int acc;
    int rx_base;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_en_a", mem_en, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_count", count, 6'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_mem_en", mem_en, 1'b0);
        advance();

        // Single byte latency
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        chk("c0_mem_en", mem_en, 1'b1);
        chk("c0_we", mem_write_enable, 1'b1);
        chk("c0_addr", mem_address, 6'd0);
        chk("c0_data", mem_data, 8'hA5);
        chk("c0_in_ready", in_ready, 1'b1);
        advance();
        in_valid = 1'b0;
        #1;
        chk("c1_mem_en", mem_en, 1'b1);
        chk("c1_we", mem_write_enable, 1'b0);
        chk("c1_addr", mem_address, 6'd0);
        chk("c1_in_ready", in_ready, 1'b0);
        chk("c1_count", count, 6'd1);
        chk("c1_out_valid", out_valid, 1'b0);
        advance();
        #1;
        chk("c2_mem_en", mem_en, 1'b1);
        chk("c2_we", mem_write_enable, 1'b0);
        chk("c2_out_valid", out_valid, 1'b0);
        advance();
        #1;
        chk("c3_out_valid", out_valid, 1'b1);
        chk("c3_out_data", out_data, 8'hA5);
        chk("c3_count", count, 6'd0);
        advance();
        #1;
        chk("c4_out_valid", out_valid, 1'b0);
        chk("c4_empty", empty, 1'b1);
        advance();

        // Fill to 33 with no consumer
        out_ready = 1'b0;
        nxt = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(nxt);
            #1;
            if (in_ready) nxt++;
            advance();
        end
        in_valid = 1'b1;
        in_data  = 8'(nxt);
        #1;
        chk("fill_accepted", nxt, 33);
        chk("fill_count", count, 6'd32);
        chk("fill_full", full, 1'b1);
        chk("fill_in_ready", in_ready, 1'b0);
        chk("fill_no_write", mem_en, 1'b0);
        chk("fill_out_valid", out_valid, 1'b1);
        chk("fill_out_data", out_data, 8'h00);
        chk("fill_sb_size", q.size(), 33);
        chk("fill_sb_last", q[32], 8'h20);
        advance();
        chk("fill_still_full", count, 6'd32);
        drain(150);

        // Backpressure on the output register
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        #1;
        chk("bp_push", in_ready, 1'b1);
        advance();
        in_valid = 1'b0;
        #1;
        advance();
        #1;
        advance();
        #1;
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_out_data0", out_data, 8'h55);
        advance();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            #1;
            chk("bp_hold_data", out_data, 8'h55);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_count", count, 6'(i));
            chk("bp_write", {mem_en, mem_write_enable}, 2'b11);
            advance();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_count_end", count, 6'd10);
        chk("bp_data_end", out_data, 8'h55);
        advance();
        drain(100);

        // Random-handshake streaming across pointer wrap
        sent    = 0;
        rx_base = rx_cnt;
        for (int i = 0; i < 3000 && (sent < 80 || q.size() != 0); i++) begin
            in_valid  = (sent < 80) && ($urandom_range(0, 3) != 0);
            in_data   = 8'(8'h80 + sent);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) sent++;
            advance();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("wrap_sent", sent, 80);
        chk("wrap_rx", rx_cnt - rx_base, 80);
        chk("wrap_empty", empty, 1'b1);
        advance();

        // Reset while a read is outstanding
        acc = 0;
        for (int i = 0; i < 20 && acc < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + acc);
            #1;
            if (in_ready) acc++;
            advance();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mr_count5", count, 6'd5);
        chk("mr_out_valid", out_valid, 1'b1);
        chk("mr_out_data", out_data, 8'hC0);
        advance();
        out_ready = 1'b0;
        #1;
        chk("mr_issue_en", mem_en, 1'b1);
        chk("mr_issue_we", mem_write_enable, 1'b0);
        chk("mr_issue_count", count, 6'd5);
        chk("mr_issue_ready", in_ready, 1'b0);
        advance();
        rst_n = 1'b0;
        #1;
        chk("mr_rst_in_ready", in_ready, 1'b0);
        chk("mr_rst_mem_en", mem_en, 1'b0);
        q.delete();
        advance();
        rst_n = 1'b1;
        #1;
        chk("mr_after_count", count, 6'd0);
        chk("mr_after_out_valid", out_valid, 1'b0);
        chk("mr_after_out_data", out_data, 8'd0);
        chk("mr_after_empty", empty, 1'b1);
        chk("mr_after_full", full, 1'b0);
        chk("mr_after_mem_en", mem_en, 1'b0);
        chk("mr_after_in_ready", in_ready, 1'b1);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
